// File: rtl/tnoc_input_port_requester.sv
// tnoc_input_port_requester
// Requester side of the input-port / output-port-controller handshake.
// Each virtual channel runs a small IDLE/HEADER/BODY framing FSM, latches
// the one-hot route of its header flit and drives request, start/end of
// packet and free toward the single output port it is routed to.
// Optional feature: define TNOC_INPUT_REQUESTER_WATCHDOG_EN to build a
// per-VC stall counter that flags a request left ungranted for
// WATCHDOG_CYCLES cycles through o_protocol_error.
module tnoc_input_port_requester #(
    parameter int CHANNELS        = 2,
    parameter int WATCHDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   i_valid,
    input  logic [CHANNELS-1:0]   i_head,
    input  logic [CHANNELS-1:0]   i_tail,
    input  logic [5*CHANNELS-1:0] i_route,
    output logic [CHANNELS-1:0]   o_pop,
    output logic [5*CHANNELS-1:0] o_request,
    output logic [5*CHANNELS-1:0] o_start_of_packet,
    output logic [5*CHANNELS-1:0] o_end_of_packet,
    output logic [5*CHANNELS-1:0] o_free,
    input  logic [5*CHANNELS-1:0] i_grant,
    output logic                  o_protocol_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BODY   = 2'd2
    } state_t;

    logic [CHANNELS-1:0] vc_error;
    logic [CHANNELS-1:0] stray_grant;
    logic                error_event;
    logic                error_reg;

`ifdef TNOC_INPUT_REQUESTER_WATCHDOG_EN
    localparam int STALL_W = $clog2(WATCHDOG_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(WATCHDOG_CYCLES);
    logic [CHANNELS-1:0] stall_hit;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_vc
            state_t     state_reg;
            state_t     state_next;
            logic [4:0] route_reg;
            logic [4:0] route_next;
            logic [4:0] in_route;
            logic [4:0] request;
            logic [4:0] eff_grant;
            logic       route_onehot;
            logic       granted;
            logic       framing_error;

            assign in_route     = i_route[5*gi +: 5];
            assign route_onehot = (in_route != 5'd0) &&
                                  ((in_route & (in_route - 5'd1)) == 5'd0);

            // Only the latched port bit is ever driven, and only while a
            // packet is open and its current flit is present.
            assign request   = (state_reg != IDLE && i_valid[gi]) ? route_reg : 5'd0;
            assign eff_grant = i_grant[5*gi +: 5] & request;
            assign granted   = |eff_grant;

            assign o_request[5*gi +: 5]         = request;
            assign o_start_of_packet[5*gi +: 5] = (state_reg == HEADER) ? request : 5'd0;
            assign o_end_of_packet[5*gi +: 5]   = i_tail[gi] ? eff_grant : 5'd0;
            assign o_free[5*gi +: 5]            = i_tail[gi] ? eff_grant : 5'd0;
            assign o_pop[gi]                    = granted;

            assign stray_grant[gi] = |(i_grant[5*gi +: 5] & ~request);
            assign vc_error[gi]    = framing_error;

            // Framing FSM: next state, route capture and framing errors
            always_comb begin
                state_next    = state_reg;
                route_next    = route_reg;
                framing_error = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (i_valid[gi]) begin
                            if (i_head[gi] && route_onehot) begin
                                state_next = HEADER;
                                route_next = in_route;
                            end else begin
                                framing_error = 1'b1;
                            end
                        end
                    end
                    HEADER: begin
                        if (granted) begin
                            state_next = i_tail[gi] ? IDLE : BODY;
                        end
                    end
                    BODY: begin
                        // A stray header flag mid-packet is carried as body data.
                        if (i_valid[gi] && i_head[gi]) begin
                            framing_error = 1'b1;
                        end
                        if (granted && i_tail[gi]) begin
                            state_next = IDLE;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            // FSM state and latched route registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    route_reg <= 5'd0;
                end else begin
                    state_reg <= state_next;
                    route_reg <= route_next;
                end
            end

`ifdef TNOC_INPUT_REQUESTER_WATCHDOG_EN
            logic [STALL_W-1:0] stall_reg;

            // Stall counter: counts ungranted request cycles, saturating
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stall_reg <= '0;
                end else if (state_reg == IDLE || granted) begin
                    stall_reg <= '0;
                end else if (request != 5'd0 && stall_reg != STALL_MAX) begin
                    stall_reg <= stall_reg + 1'b1;
                end
            end

            assign stall_hit[gi] = (stall_reg == STALL_MAX);
`endif
        end
    endgenerate

`ifdef TNOC_INPUT_REQUESTER_WATCHDOG_EN
    assign error_event = (|vc_error) | (|stray_grant) | (|stall_hit);
`else
    assign error_event = (|vc_error) | (|stray_grant);
`endif

    // Sticky protocol error flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_reg <= 1'b0;
        end else if (error_event) begin
            error_reg <= 1'b1;
        end
    end

    assign o_protocol_error = error_reg;

endmodule

// File: tb/tb_tnoc_input_port_requester.sv
// Testbench for tnoc_input_port_requester: directed packet scenarios followed
// by randomized traffic, every cycle checked against a packet-level model.
module tb_tnoc_input_port_requester;

    localparam int CH = 2;
    localparam int WD = 8;
    localparam int NB = 5 * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] valid;
    logic [CH-1:0] head;
    logic [CH-1:0] tail;
    logic [NB-1:0] route;
    logic [NB-1:0] grant;
    logic [CH-1:0] pop;
    logic [NB-1:0] request;
    logic [NB-1:0] sop;
    logic [NB-1:0] eop;
    logic [NB-1:0] free;
    logic          perr;

    tnoc_input_port_requester #(
        .CHANNELS(CH),
        .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_valid(valid),
        .i_head(head),
        .i_tail(tail),
        .i_route(route),
        .o_pop(pop),
        .o_request(request),
        .o_start_of_packet(sop),
        .o_end_of_packet(eop),
        .o_free(free),
        .i_grant(grant),
        .o_protocol_error(perr)
    );

    always #5 clk = ~clk;

    // Packet-level model: port owned by the open packet (-1 = none), flits
    // already sent in it, ungranted-request cycle count, sticky error.
    int m_port[CH];
    int m_sent[CH];
    int m_stall[CH];
    bit m_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_port[i]  = -1;
            m_sent[i]  = 0;
            m_stall[i] = 0;
        end
        m_err = 1'b0;
    endtask

    task automatic clear_inputs();
        valid = '0;
        head  = '0;
        tail  = '0;
        route = '0;
        grant = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        #2;
        check("reset_request", 32'(request), 32'd0);
        check("reset_sop", 32'(sop), 32'd0);
        check("reset_eop", 32'(eop), 32'd0);
        check("reset_free", 32'(free), 32'd0);
        check("reset_pop", 32'(pop), 32'd0);
        check("reset_error", 32'(perr), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle with the currently driven inputs: predict, compare at
    // the falling edge, then advance the model across the rising edge.
    task automatic step();
        logic [NB-1:0] e_req;
        logic [NB-1:0] e_sop;
        logic [NB-1:0] e_eop;
        logic [CH-1:0] e_pop;
        logic [4:0]    r;
        logic [4:0]    g;
        bit            ev;
        e_req = '0;
        e_sop = '0;
        e_eop = '0;
        e_pop = '0;
        ev    = 1'b0;
        for (int i = 0; i < CH; i++) begin
            r = route[5*i +: 5];
            g = grant[5*i +: 5];
            if (m_port[i] >= 0 && valid[i]) begin
                e_req[5*i + m_port[i]] = 1'b1;
                if (m_sent[i] == 0) e_sop[5*i + m_port[i]] = 1'b1;
                if (g[m_port[i]]) begin
                    e_pop[i] = 1'b1;
                    if (tail[i]) e_eop[5*i + m_port[i]] = 1'b1;
                end
            end
            if (m_port[i] < 0 && valid[i] && (!head[i] || $countones(r) != 1)) ev = 1'b1;
            if (m_port[i] >= 0 && m_sent[i] > 0 && valid[i] && head[i]) ev = 1'b1;
`ifdef TNOC_INPUT_REQUESTER_WATCHDOG_EN
            if (m_stall[i] == WD) ev = 1'b1;
`endif
        end
        if ((grant & ~e_req) != '0) ev = 1'b1;

        @(negedge clk);
        check("request", 32'(request), 32'(e_req));
        check("start_of_packet", 32'(sop), 32'(e_sop));
        check("end_of_packet", 32'(eop), 32'(e_eop));
        check("free", 32'(free), 32'(e_eop));
        check("pop", 32'(pop), 32'(e_pop));
        check("protocol_error", 32'(perr), 32'(m_err));

        @(posedge clk);
        cycle++;
        if (ev) m_err = 1'b1;
        for (int i = 0; i < CH; i++) begin
            r = route[5*i +: 5];
            if (m_port[i] < 0 || e_pop[i]) m_stall[i] = 0;
            else if (valid[i] && m_stall[i] < WD) m_stall[i]++;
            if (m_port[i] < 0) begin
                if (valid[i] && head[i] && $countones(r) == 1) begin
                    for (int k = 0; k < 5; k++) if (r[k]) m_port[i] = k;
                    m_sent[i] = 0;
                end
            end else if (e_pop[i]) begin
                if (tail[i]) m_port[i] = -1;
                else m_sent[i]++;
            end
        end
        #1;
    endtask

    // Drive the flit presented by VC v
    task automatic flit(input int v, input bit vl, input bit hd, input bit tl, input logic [4:0] rt);
        valid[v]       = vl;
        head[v]        = hd;
        tail[v]        = tl;
        route[5*v +: 5] = rt;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        do_reset();

        // Single-flit packet on VC0 to port 2, granted three cycles later
        flit(0, 1, 1, 1, 5'b00100);
        step();
        step();
        step();
        grant[2] = 1'b1;
        step();
        grant = '0;
        flit(0, 0, 0, 0, 5'b00000);
        step();
        step();

        // Four-flit packet on VC1 to port 0, granted every cycle
        flit(1, 1, 1, 0, 5'b00001);
        step();
        grant[5] = 1'b1;
        step();
        flit(1, 1, 0, 0, 5'b00000);
        step();
        step();
        flit(1, 1, 0, 1, 5'b00000);
        step();
        grant = '0;
        flit(1, 0, 0, 0, 5'b00000);
        step();

        // Both VCs to port 3, grants alternating between them
        flit(0, 1, 1, 0, 5'b01000);
        flit(1, 1, 1, 0, 5'b01000);
        step();
        for (int k = 0; k < 4; k++) begin
            grant = '0;
            grant[(k % 2 == 0) ? 3 : 8] = 1'b1;
            step();
            if (k % 2 == 0) flit(0, 1, 0, 1, 5'b00000);
            else flit(1, 1, 0, 1, 5'b00000);
        end
        grant = '0;
        flit(0, 0, 0, 0, 5'b00000);
        flit(1, 0, 0, 0, 5'b00000);
        step();

        // Valid gap mid-packet on VC0 (port 4)
        flit(0, 1, 1, 0, 5'b10000);
        step();
        grant[4] = 1'b1;
        step();
        grant = '0;
        flit(0, 0, 0, 0, 5'b00000);
        step();
        step();
        flit(0, 1, 0, 1, 5'b00000);
        step();
        grant[4] = 1'b1;
        step();
        grant = '0;
        flit(0, 0, 0, 0, 5'b00000);
        step();

        // Long stall: trips the watchdog only when it is built
        flit(0, 1, 1, 0, 5'b00010);
        for (int k = 0; k < WD + 4; k++) step();
        do_reset();

        // Body flit in IDLE, then a multi-hot header: error, nothing moves
        flit(0, 1, 0, 0, 5'b00000);
        step();
        flit(0, 1, 1, 1, 5'b00011);
        step();
        step();
        flit(0, 0, 0, 0, 5'b00000);
        step();
        do_reset();
        step();

        // Randomized well-formed traffic on all VCs
        for (int c = 0; c < 400; c++) begin
            grant = '0;
            for (int i = 0; i < CH; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                tail[i]  = ($urandom_range(0, 2) == 0);
                if (m_port[i] < 0) begin
                    head[i] = 1'b1;
                    route[5*i +: 5] = 5'(1 << $urandom_range(0, 4));
                end else begin
                    head[i] = 1'b0;
                    route[5*i +: 5] = 5'($urandom_range(0, 31));
                    if (valid[i] && $urandom_range(0, 1) == 1) grant[5*i + m_port[i]] = 1'b1;
                end
            end
            step();
        end

        // Randomized unconstrained traffic, including protocol violations
        for (int c = 0; c < 150; c++) begin
            valid = CH'($urandom);
            head  = CH'($urandom);
            tail  = CH'($urandom);
            route = NB'($urandom);
            grant = NB'($urandom) & NB'($urandom);
            step();
        end
        do_reset();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tnoc_input_port_requester.md
Name: tnoc_input_port_requester

Overview:
- Requester end of the per-output port-control handshake: one instance per router input port, facing the five output-side internal port controllers.
- Per virtual channel, it tracks packet framing of the flit at the head of the input VC FIFO and latches the one-hot route of the head flit.
- It drives request / start_of_packet / end_of_packet / free toward the routed output port, consumes grants, and pops the VC FIFO on each granted flit.

Parameters:
- CHANNELS, 2, number of virtual channels (1..8).
- WATCHDOG_CYCLES, 1024, stall limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_valid  input  CHANNELS  VC FIFO head flit valid, per VC
- i_head  input  CHANNELS  head flit is a header flit
- i_tail  input  CHANNELS  head flit is a tail flit (single-flit packet: head and tail both 1)
- i_route  input  5*CHANNELS  one-hot output port for VC i, bits [5i+4:5i]; sampled with the header flit
- o_pop  output  CHANNELS  pop VC FIFO; flit transferred this cycle
- o_request  output  5*CHANNELS  bit 5i+j: VC i requests output port j
- o_start_of_packet  output  5*CHANNELS  header flit awaiting output port ownership
- o_end_of_packet  output  5*CHANNELS  tail flit transferred; releases port arbiter
- o_free  output  5*CHANNELS  tail flit transferred; releases VC arbiter
- i_grant  input  5*CHANNELS  bit 5i+j: output port j accepts VC i flit this cycle
- o_protocol_error  output  1  sticky framing/route error flag

Behaviour:
- Reset (async assert, sync release): all VC FSMs go to IDLE; route registers are cleared; all outputs are 0, including the sticky error. Reset mid-packet abandons the packet and issues no end_of_packet/free.
- Per-VC FSM states:
  - IDLE: if i_valid & i_head and i_route is exactly one-hot, latch the route and go to HEADER. No pop in IDLE, so request latency is 1 cycle after the header appears.
  - HEADER: request = start_of_packet = i_valid at the latched port. On grant with tail: pop, pulse end_of_packet/free, go to IDLE. On grant without tail: pop, go to BODY.
  - BODY: request = i_valid at the latched port; start_of_packet is 0. On grant: pop. On grant with tail: pulse end_of_packet/free and go to IDLE.
- Only the latched port bit of a VC is ever driven; the other 4 bits are 0.
- Effective grant = i_grant & o_request. A grant on a deasserted request is ignored and sets o_protocol_error. Several grants on one VC cannot occur, because only one port is driven.
- o_pop[i] = OR of effective grants of VC i, same cycle, combinational from i_grant.
- end_of_packet and free are combinational from the granted tail flit: 1-cycle pulses in the grant cycle.
- Back-to-back packets: after a tail grant the VC re-enters IDLE, so the next header is requested 1 cycle later. Bubble = 1 cycle.
- i_valid dropping mid-packet: request drops, state is held, no pop.
- Error cases (each sets o_protocol_error, which stays set until reset):
  - Non-header flit valid in IDLE: not popped, VC stays IDLE.
  - Header with zero or multi-hot route: VC stays IDLE, not popped.
  - Header flag seen in BODY: treated as a body flit.
- VCs are fully independent. Simultaneous grants to different VCs on different ports are all honoured in the same cycle.

Optional Feature:
- Macro: TNOC_INPUT_REQUESTER_WATCHDOG_EN.
- When defined: each VC has a stall counter of width clog2(WATCHDOG_CYCLES+1).
  - It increments while request is asserted and not effectively granted, and clears on grant or in IDLE.
  - It saturates at WATCHDOG_CYCLES; reaching WATCHDOG_CYCLES sets o_protocol_error.
- When undefined: no counters are built, and o_protocol_error reflects framing/route errors only.

Test Plan:
- Single-flit packet, VC0, route 5'b00100, grant at cycle t+3 -> o_request/o_start_of_packet bit 2 high from t+1; at t+3 o_pop[0], o_end_of_packet[2] and o_free[2] pulse 1 cycle; then all zero.
- 4-flit packet, VC1, route 5'b00001, grant every cycle -> start_of_packet only on the header cycle; 4 pops; end_of_packet/free bits 5 on the 4th pop only.
- VC0 to port 3 and VC1 to port 3, grants alternating -> each VC pops only in its granted cycles; each tail pulses free once.
- i_valid low for 2 cycles mid-packet -> request low, no pop, state held, resumes in BODY with start_of_packet 0.
- Body flit in IDLE, then route 5'b00011 header -> no request, no pop, o_protocol_error=1; rst_n pulse clears it.
- With watchdog, WATCHDOG_CYCLES=8, request never granted -> o_protocol_error rises after 8 cycles. Without the macro, it stays 0.
